display_src_seq: RTL and testbench
==================================

DISPLAY_SRC_SEQ -- requirements
Module: display_src_seq

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3, number of display sources (legal 2..8).
REQ-002 SHALL have parameter DIGITS, default 4, digits per source.
REQ-003 SHALL have parameter DIG_W, default 4, bits per digit (BCD).
REQ-004 SHALL have parameter BLINK_DIV, default 25000000, clock cycles per blink half-period (>=2).
REQ-005 SHALL have parameter RESET_SEL, default 0, selection after reset (< NUM_SRC); SEL_W = max(1, clog2(NUM_SRC)).
REQ-006 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port src_data  in  NUM_SRC*DIGITS*DIG_W  source s, digit d at bits [(s*DIGITS+d)*DIG_W +: DIG_W]; digit 0 = rightmost ones.
REQ-009 SHALL have port mode_next  in  1  one-cycle pulse, advance selection.
REQ-010 SHALL have port mode_load  in  1  load mode_sel as selection.
REQ-011 SHALL have port mode_sel  in  SEL_W  direct selection value.
REQ-012 SHALL have port freeze  in  1  hold displayed digits.
REQ-013 SHALL have port blink_mask  in  DIGITS  per-digit blink enable.
REQ-014 SHALL have port lz_blank  in  1  leading-zero blanking enable.
REQ-015 SHALL have port digits_out  out  DIGITS*DIG_W  registered digit values, same packing as one source.
REQ-016 SHALL have port digit_en  out  DIGITS  registered per-digit lit flag (1 = lit).
REQ-017 SHALL have port cur_sel  out  SEL_W  registered current selection.
REQ-018 SHALL have port switch_pulse  out  1  one-cycle flag, selection changed.

Function
REQ-019 Selection: mode_load has priority over mode_next; load with mode_sel >= NUM_SRC or == cur_sel SHALL leave cur_sel unchanged.
REQ-020 mode_next SHALL set cur_sel to cur_sel+1, wrapping NUM_SRC-1 -> 0.
REQ-021 switch_pulse SHALL be 1 in exactly the cycle cur_sel first shows a new value; no pulse for ignored or same-value loads.
REQ-022 Latency: cur_sel updates at edge k after a request sampled at edge k; digits_out/digit_en reflect the new source from edge k+1.
REQ-023 When freeze=0, digits_out SHALL register src_data of cur_sel every cycle; when freeze=1, digits_out and digit_en SHALL hold; selection changes still accepted and cur_sel/switch_pulse update normally.
REQ-024 Blink counter SHALL count 0..BLINK_DIV-1 and toggle blink_phase on wrap; counter SHALL clear to 0 and blink_phase set to 1 on any selection change.
REQ-025 Leading-zero blanking: with lz_blank=1, digit d (d>=1) SHALL be blanked when it and all higher digits are 0; digit 0 SHALL never be LZ-blanked.
REQ-026 digit_en[d] SHALL be registered as NOT lz_blanked[d] AND NOT (blink_mask[d] AND blink_phase==0), computed from the same source value loaded into digits_out.
REQ-027 Blink counter SHALL run regardless of freeze.

Reset
REQ-028 On rst=1 at a rising edge: cur_sel=RESET_SEL, digits_out=0, digit_en=0, switch_pulse=0, blink counter=0, blink_phase=1.
REQ-029 rst SHALL override all inputs in the same cycle; pending requests SHALL be discarded; first display load occurs at the first edge with rst=0 (if freeze=0).

Verification
REQ-030 Reset, NUM_SRC=3, src0=1234 -> cur_sel=0, digit_en=0000; one cycle after release digits_out=1234, digit_en=1111.
REQ-031 Three mode_next pulses from sel 0 -> cur_sel 1,2,0, switch_pulse once per step, digits_out follows one cycle later.
REQ-032 mode_load with mode_sel=3 (NUM_SRC=3) and simultaneous mode_next -> cur_sel unchanged, switch_pulse=0.
REQ-033 freeze=1, src change 1234->5678, mode_next -> digits_out stays 1234, cur_sel changes; freeze=0 -> next cycle shows new source.
REQ-034 BLINK_DIV=4, blink_mask=0011, src=0012, lz_blank=1 -> digit_en toggles 0011/0000 every 4 cycles; digits 3,2 always blanked.

Source files
------------

// File: rtl/display_src_seq.sv
// display_src_seq: selects one of NUM_SRC BCD digit groups for display,
// with request-driven source switching, display freeze, per-digit blink
// and leading-zero blanking. All outputs are registered.
module display_src_seq #(
    parameter  int NUM_SRC   = 3,
    parameter  int DIGITS    = 4,
    parameter  int DIG_W     = 4,
    parameter  int BLINK_DIV = 25000000,
    parameter  int RESET_SEL = 0,
    localparam int SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_SRC*DIGITS*DIG_W-1:0]  src_data,
    input  logic                             mode_next,
    input  logic                             mode_load,
    input  logic [SEL_W-1:0]                 mode_sel,
    input  logic                             freeze,
    input  logic [DIGITS-1:0]                blink_mask,
    input  logic                             lz_blank,
    output logic [DIGITS*DIG_W-1:0]          digits_out,
    output logic [DIGITS-1:0]                digit_en,
    output logic [SEL_W-1:0]                 cur_sel,
    output logic                             switch_pulse
);

    localparam int              GRP_W    = DIGITS * DIG_W;
    localparam int              CNT_W    = $clog2(BLINK_DIV);
    localparam logic [SEL_W:0]  LP_NUM   = (SEL_W+1)'(NUM_SRC);
    localparam logic [SEL_W-1:0] LP_LAST = SEL_W'(NUM_SRC - 1);
    localparam logic [SEL_W-1:0] LP_RST  = SEL_W'(RESET_SEL);
    localparam logic [CNT_W-1:0] LP_WRAP = CNT_W'(BLINK_DIV - 1);

    logic [SEL_W-1:0]  r_sel;
    logic              r_pulse;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_phase;
    logic [GRP_W-1:0]  r_digits;
    logic [DIGITS-1:0] r_en;

    logic              w_load_ok;
    logic              w_next;
    logic              w_change;
    logic [SEL_W-1:0]  w_sel_nxt;
    logic [GRP_W-1:0]  w_src;
    logic [DIGITS-1:0] w_lz;
    logic [DIGITS-1:0] w_en;

    // A load always wins over next, even when the load itself is ignored
    // (out of range or same as the current selection).
    assign w_load_ok = mode_load && ({1'b0, mode_sel} < LP_NUM) && (mode_sel != r_sel);
    assign w_next    = !mode_load && mode_next;
    assign w_change  = w_load_ok || w_next;

    // Next selection value: direct load, or increment with wrap.
    always_comb begin
        w_sel_nxt = r_sel;
        if (w_load_ok) begin
            w_sel_nxt = mode_sel;
        end else if (w_next) begin
            w_sel_nxt = (r_sel == LP_LAST) ? '0 : r_sel + SEL_W'(1);
        end
    end

    // Source multiplexer driven by the registered selection, so the display
    // follows a selection change one cycle after cur_sel.
    always_comb begin
        w_src = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (r_sel == SEL_W'(s)) begin
                w_src = src_data[s*GRP_W +: GRP_W];
            end
        end
    end

    // Leading-zero blanking scanned from the top digit down; digit 0 is
    // always kept so a zero value still shows a single 0. Blink is then
    // applied per digit while the blink phase is low.
    always_comb begin
        logic v_allz;
        v_allz = 1'b1;
        w_lz   = '0;
        w_en   = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            v_allz  = v_allz && (w_src[d*DIG_W +: DIG_W] == '0);
            w_lz[d] = lz_blank && (d != 0) && v_allz;
            w_en[d] = !w_lz[d] && !(blink_mask[d] && !r_phase);
        end
    end

    // Selection register and one-cycle change flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel   <= LP_RST;
            r_pulse <= 1'b0;
        end else begin
            r_sel   <= w_sel_nxt;
            r_pulse <= w_change;
        end
    end

    // Blink timebase: free-running regardless of freeze, restarted in the
    // lit phase on every selection change so a new source appears lit.
    always_ff @(posedge clk) begin
        if (rst || w_change) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (r_cnt == LP_WRAP) begin
            r_cnt   <= '0;
            r_phase <= !r_phase;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Display registers: reload every cycle unless frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits <= '0;
            r_en     <= '0;
        end else if (!freeze) begin
            r_digits <= w_src;
            r_en     <= w_en;
        end
    end

    assign digits_out   = r_digits;
    assign digit_en     = r_en;
    assign cur_sel      = r_sel;
    assign switch_pulse = r_pulse;

endmodule

// File: tb/tb_display_src_seq.sv
// Testbench for display_src_seq: directed scenarios followed by randomized
// traffic, all checked each cycle against a decimal-level reference model.
module tb_display_src_seq;

    localparam int NS = 3;
    localparam int D  = 4;
    localparam int W  = 4;
    localparam int BD = 4;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS*D*W-1:0] src_data;
    logic              mode_next;
    logic              mode_load;
    logic [SW-1:0]     mode_sel;
    logic              freeze;
    logic [D-1:0]      blink_mask;
    logic              lz_blank;
    logic [D*W-1:0]    digits_out;
    logic [D-1:0]      digit_en;
    logic [SW-1:0]     cur_sel;
    logic              switch_pulse;

    int src_val [NS];

    // reference model state (decimal values, tick count since last restart)
    int        m_sel;
    int        m_dig;
    logic [D-1:0] m_en;
    bit        m_pulse;
    int        m_t;

    int total = 0;
    int bad   = 0;

    display_src_seq #(
        .NUM_SRC(NS), .DIGITS(D), .DIG_W(W), .BLINK_DIV(BD), .RESET_SEL(0)
    ) dut (
        .clk(clk), .rst(rst), .src_data(src_data), .mode_next(mode_next),
        .mode_load(mode_load), .mode_sel(mode_sel), .freeze(freeze),
        .blink_mask(blink_mask), .lz_blank(lz_blank), .digits_out(digits_out),
        .digit_en(digit_en), .cur_sel(cur_sel), .switch_pulse(switch_pulse)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [D*W-1:0] to_bcd(input int v);
        logic [D*W-1:0] r = '0;
        for (int d = 0; d < D; d++) r[d*W +: W] = W'((v / pow10(d)) % 10);
        return r;
    endfunction

    always_comb begin
        src_data = '0;
        for (int s = 0; s < NS; s++) src_data[s*D*W +: D*W] = to_bcd(src_val[s]);
    end

    // Lit pattern from the decimal value: digits above the most significant
    // nonzero digit are blanked (never digit 0); blink hides masked digits
    // during odd blink half-periods.
    function automatic logic [D-1:0] exp_lit(input int v, input logic [D-1:0] mask,
                                             input bit lz, input int t);
        logic [D-1:0] r;
        int  msd = 0;
        bit  dark = ((t / BD) % 2) == 1;
        for (int d = 0; d < D; d++) if (((v / pow10(d)) % 10) != 0) msd = d;
        for (int d = 0; d < D; d++)
            r[d] = !(lz && d > msd) && !(mask[d] && dark);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int  old = m_sel;
        int  nsel = m_sel;
        if (rst) begin
            m_sel = 0; m_dig = 0; m_en = '0; m_pulse = 0; m_t = 0;
            return;
        end
        if (!freeze) begin
            m_dig = src_val[old];
            m_en  = exp_lit(src_val[old], blink_mask, lz_blank, m_t);
        end
        if (mode_load) begin
            if (int'(mode_sel) < NS) nsel = int'(mode_sel);
        end else if (mode_next) begin
            nsel = (m_sel + 1) % NS;
        end
        m_pulse = (nsel != m_sel);
        m_sel   = nsel;
        m_t     = m_pulse ? 0 : m_t + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("sel",   32'(cur_sel),      32'(m_sel));
        check("pulse", 32'(switch_pulse), 32'(m_pulse));
        check("dig",   32'(digits_out),   32'(to_bcd(m_dig)));
        check("en",    32'(digit_en),     32'(m_en));
        mode_next = 1'b0;
        mode_load = 1'b0;
    endtask

    function automatic int rnd_val();
        case ($urandom_range(0, 4))
            0: return 0;
            1: return int'($urandom_range(0, 9));
            2: return int'($urandom_range(0, 99));
            3: return int'($urandom_range(0, 999));
            default: return int'($urandom_range(0, 9999));
        endcase
    endfunction

    initial begin
        rst = 1'b1; mode_next = 0; mode_load = 0; mode_sel = '0; freeze = 0;
        blink_mask = '0; lz_blank = 0;
        src_val[0] = 1234; src_val[1] = 5678; src_val[2] = 42;
        m_sel = 0; m_dig = 0; m_en = '0; m_pulse = 0; m_t = 0;

        // reset with a pending request that must be discarded
        mode_next = 1'b1;
        tick();
        tick();
        check("rst_sel", 32'(cur_sel), 32'd0);
        check("rst_en",  32'(digit_en), 32'd0);
        rst = 1'b0;
        tick();
        check("first_dig", 32'(digits_out), 32'h1234);
        check("first_en",  32'(digit_en), 32'hF);

        // three next pulses: 1, 2, 0
        for (int i = 0; i < 3; i++) begin
            mode_next = 1'b1;
            tick();
            check("next_sel", 32'(cur_sel), 32'((i + 1) % NS));
            check("next_pls", 32'(switch_pulse), 32'd1);
            tick();
            check("next_pls0", 32'(switch_pulse), 32'd0);
        end

        // ignored load of 3 with simultaneous next
        mode_load = 1'b1; mode_sel = 2'd3; mode_next = 1'b1;
        tick();
        check("bad_load_sel", 32'(cur_sel), 32'd0);
        check("bad_load_pls", 32'(switch_pulse), 32'd0);
        // same-value load
        mode_load = 1'b1; mode_sel = 2'd0;
        tick();
        check("same_load_pls", 32'(switch_pulse), 32'd0);

        // freeze holds 1234 while source changes and selection moves
        freeze = 1'b1; src_val[0] = 5678; mode_next = 1'b1;
        tick();
        tick();
        check("frz_dig", 32'(digits_out), 32'h1234);
        check("frz_sel", 32'(cur_sel), 32'd1);
        freeze = 1'b0; src_val[1] = 9021;
        tick();
        check("unfrz_dig", 32'(digits_out), 32'h9021);

        // blink with leading-zero blanking on source 0012
        mode_load = 1'b1; mode_sel = 2'd0; src_val[0] = 12;
        blink_mask = 4'b0011; lz_blank = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) begin
            tick();
            check("lz_hi", 32'(digit_en[3:2]), 32'd0);
        end

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            mode_next = ($urandom_range(0, 3) == 0);
            mode_load = ($urandom_range(0, 5) == 0);
            mode_sel  = SW'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) freeze = ~freeze;
            if ($urandom_range(0, 15) == 0) blink_mask = D'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(0, 3) == 0) src_val[$urandom_range(0, NS-1)] = rnd_val();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
